// File: rtl/spi_mnrch_arb.sv
// Round-robin arbiter sharing one SPI_mnrch transactor between two clients.
// Forwards the winner's command, returns resp/done to the winner only, and steers SS_n.
module spi_mnrch_arb #(
  parameter int unsigned GAP = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [15:0] cmd0,
  output logic        done0,
  output logic        SS0_n,
  input  logic        req1,
  input  logic [15:0] cmd1,
  output logic        done1,
  output logic        SS1_n,
  output logic [15:0] resp,
  output logic        snd,
  output logic [15:0] cmd,
  input  logic        m_done,
  input  logic [15:0] m_resp,
  input  logic        m_SS_n
);

  typedef enum logic [1:0] {StIdle, StSend, StBusy, StGap} state_e;

  // Gap counter loads GAP-1 so that exactly GAP cycles are spent in StGap.
  localparam logic [3:0] GapLast = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  state_e     state_q;
  logic       gnt_q;
  logic       last_q;
  logic [3:0] gap_cnt_q;
  logic       win;
  logic       active;

  // On a tie the client that was not served last wins.
  always_comb begin
    win = 1'b0;
    if (req0 && req1) begin
      win = ~last_q;
    end else if (req1) begin
      win = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      gap_cnt_q <= 4'd0;
      snd       <= 1'b0;
      cmd       <= 16'h0000;
      resp      <= 16'h0000;
      done0     <= 1'b0;
      done1     <= 1'b0;
    end else begin
      snd   <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req0 || req1) begin
            gnt_q   <= win;
            cmd     <= win ? cmd1 : cmd0;
            snd     <= 1'b1;
            state_q <= StSend;
          end
        end
        StSend: begin
          state_q <= StBusy;
        end
        StBusy: begin
          if (m_done) begin
            resp      <= m_resp;
            last_q    <= gnt_q;
            done0     <= ~gnt_q;
            done1     <= gnt_q;
            gap_cnt_q <= GapLast;
            state_q   <= (GAP == 0) ? StIdle : StGap;
          end
        end
        StGap: begin
          if (gap_cnt_q == 4'd0) begin
            state_q <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Only the granted client's device sees the monarch's slave select.
  assign active = (state_q == StSend) || (state_q == StBusy);
  assign SS0_n  = (active && !gnt_q) ? m_SS_n : 1'b1;
  assign SS1_n  = (active &&  gnt_q) ? m_SS_n : 1'b1;

endmodule
